instr_fetch_unit: RTL and testbench

- Instruction fetch stage; sits directly upstream of the IF/ID pipeline register.
- Holds the fetch PC and issues in-order word requests to the instruction memory/cache over a request/response handshake.
- Buffers returned words in a small FIFO and presents one instruction per cycle as Instr1_IF / Instr_PC_IF / Instr_PC_Plus4_IF.
- Handles PC redirects by squashing buffered and in-flight fetches.

---
 rtl/instr_fetch_unit_if.sv | 24 ++
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response channel between fetch and the I-side memory.
interface instr_fetch_unit_if;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic        Mem_Ready;
    logic        Mem_Resp_Valid;
    logic [31:0] Mem_Resp_Data;

    modport master (
        output Mem_Req,
        output Mem_Addr,
        input  Mem_Ready,
        input  Mem_Resp_Valid,
        input  Mem_Resp_Data
    );

    modport slave (
        input  Mem_Req,
        input  Mem_Addr,
        output Mem_Ready,
        output Mem_Resp_Valid,
        output Mem_Resp_Data
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, credit-limited memory requests, instruction FIFO, redirect squash.
// Optional macro FETCH_TRACE_EN compiles in a request/response/redirect trace.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'hBFC00000,
    parameter int          BUF_DEPTH       = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               STALL,
    input  logic               Request_Alt_PC,
    input  logic [31:0]        Alt_PC,
    instr_fetch_unit_if.master mem,
    output logic [31:0]        Instr1_IF,
    output logic [31:0]        Instr_PC_IF,
    output logic [31:0]        Instr_PC_Plus4_IF,
    output logic               Instr_Valid_IF
);
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = ((CW > OW) ? CW : OW) + 1;

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_DRAIN} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_resp_pc;
    logic [31:0]     r_fifo_instr [BUF_DEPTH];
    logic [31:0]     r_fifo_pc    [BUF_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [OW-1:0]   r_outst;
    logic [OW-1:0]   r_discard;

    logic [31:0]     w_alt_pc;
    logic [SW-1:0]   w_inflight;
    logic            w_req;
    logic            w_accept;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic [OW-1:0]   w_outst_next;

    assign w_alt_pc   = {Alt_PC[31:2], 2'b00};
    assign w_inflight = SW'(r_count) + SW'(r_outst);

    // Credits cover FIFO slots, so every returning word has a place to land.
    assign w_req = (r_state == S_FETCH) && !Request_Alt_PC
                && (r_outst < OW'(MAX_OUTSTANDING))
                && (w_inflight < SW'(BUF_DEPTH));

    assign w_accept     = w_req && mem.Mem_Ready;
    assign w_drop       = mem.Mem_Resp_Valid && (r_discard != '0);
    assign w_push       = mem.Mem_Resp_Valid && (r_discard == '0)
                       && !Request_Alt_PC;
    assign w_pop        = Instr_Valid_IF && !STALL && !Request_Alt_PC;
    assign w_outst_next = r_outst + OW'(w_accept) - OW'(mem.Mem_Resp_Valid);

    assign mem.Mem_Req  = w_req;
    assign mem.Mem_Addr = r_fetch_pc;

    assign Instr_Valid_IF    = (r_count != '0);
    assign Instr1_IF         = Instr_Valid_IF ? r_fifo_instr[r_rptr] : 32'h0;
    assign Instr_PC_IF       = Instr_Valid_IF ? r_fifo_pc[r_rptr] : 32'h0;
    assign Instr_PC_Plus4_IF = Instr_Valid_IF ? (r_fifo_pc[r_rptr] + 32'd4)
                                              : 32'h0;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_BOOT:  w_state_next = S_FETCH;
            S_FETCH: w_state_next = S_FETCH;
            S_DRAIN: if (r_discard == '0) w_state_next = S_FETCH;
            default: w_state_next = S_BOOT;
        endcase
        if (Request_Alt_PC)
            w_state_next = (w_outst_next != '0) ? S_DRAIN : S_FETCH;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= S_BOOT;
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_outst    <= '0;
            r_discard  <= '0;
        end else begin
            r_state <= w_state_next;
            r_outst <= w_outst_next;
            if (Request_Alt_PC) begin
                // The same-cycle response is already inside w_outst_next.
                r_fetch_pc <= w_alt_pc;
                r_resp_pc  <= w_alt_pc;
                r_discard  <= w_outst_next;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_count    <= '0;
            end else begin
                if (w_accept)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_drop)
                    r_discard <= r_discard - OW'(1);
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_wptr    <= r_wptr + AW'(1);
                end
                if (w_pop)
                    r_rptr <= r_rptr + AW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_instr[r_wptr] <= mem.Mem_Resp_Data;
            r_fifo_pc[r_wptr]    <= r_resp_pc;
        end
    end

`ifdef FETCH_TRACE_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            if (w_accept)
                $display("IF:req@%x", r_fetch_pc);
            if (w_push)
                $display("IF:Instr@%x=%x;Next@%x", r_resp_pc,
                         mem.Mem_Resp_Data, r_resp_pc + 32'd4);
            if (mem.Mem_Resp_Valid && !w_push)
                $display("IF:discard %x", mem.Mem_Resp_Data);
            if (Request_Alt_PC)
                $display("IF:redirect->%x", w_alt_pc);
        end
    end
`else
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model, scoreboard and stimulus table.
module tb_instr_fetch_unit;
    localparam logic [31:0] RPC = 32'hBFC00000;
    localparam int          MAXO = 2;

    typedef struct {
        logic [31:0] addr;
        int          age;
        bit          stale;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          n;
        bit          stall;
        bit          ready;
        bit          alt;
        logic [31:0] tgt;
        int          lat;
        int          exp_req_last;
    } vec_t;

    logic        CLK;
    logic        RESET;
    logic        STALL;
    logic        Request_Alt_PC;
    logic [31:0] Alt_PC;
    logic [31:0] Instr1_IF;
    logic [31:0] Instr_PC_IF;
    logic [31:0] Instr_PC_Plus4_IF;
    logic        Instr_Valid_IF;

    instr_fetch_unit_if mif();

    instr_fetch_unit dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .STALL             (STALL),
        .Request_Alt_PC    (Request_Alt_PC),
        .Alt_PC            (Alt_PC),
        .mem               (mif.master),
        .Instr1_IF         (Instr1_IF),
        .Instr_PC_IF       (Instr_PC_IF),
        .Instr_PC_Plus4_IF (Instr_PC_Plus4_IF),
        .Instr_Valid_IF    (Instr_Valid_IF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          nvec = 0;
    int          nerr = 0;
    pend_t       pend[$];
    exp_t        expq[$];
    logic [31:0] model_pc;
    bit          stall, ready, alt;
    logic [31:0] tgt;
    int          lat;
    bit          last_req;
    logic [31:0] last_addr;
    bit          prev_alt, prev_push, prev_hold;
    logic [31:0] prev_pc, prev_instr;
    int          npop;
    logic [31:0] first_pc, first_instr, first_p4;
    bit          want_first;
    logic [31:0] want_pc;
    bit          saw_wrap;
    vec_t        tbl[12];

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h9BC80001;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        pend.delete();
        expq.delete();
        model_pc   = RPC;
        prev_alt   = 0;
        prev_push  = 0;
        prev_hold  = 0;
        npop       = 0;
        want_first = 0;
    endtask

    function automatic int n_stale();
        int c = 0;
        foreach (pend[i]) if (pend[i].stale) c++;
        return c;
    endfunction

    task automatic cycle();
        bit    rsp;
        pend_t p;
        exp_t  e;
        rsp = (pend.size() > 0) && (pend[0].age >= lat);
        mif.Mem_Resp_Valid = rsp;
        mif.Mem_Resp_Data  = rsp ? data_of(pend[0].addr) : 32'h0;
        mif.Mem_Ready      = ready;
        STALL              = stall;
        Request_Alt_PC     = alt;
        Alt_PC             = tgt;
        #1;
        last_req  = mif.Mem_Req;
        last_addr = mif.Mem_Addr;
        if (!Instr_Valid_IF) begin
            chk("bubble_instr", Instr1_IF, 32'h0);
            chk("bubble_pc", Instr_PC_IF, 32'h0);
            chk("bubble_pc4", Instr_PC_Plus4_IF, 32'h0);
        end
        if (prev_alt)
            chk("post_redirect_valid", 32'(Instr_Valid_IF), 32'd0);
        if (prev_push)
            chk("resp_latency_valid", 32'(Instr_Valid_IF), 32'd1);
        if (prev_hold) begin
            chk("stall_head_pc", Instr_PC_IF, prev_pc);
            chk("stall_head_instr", Instr1_IF, prev_instr);
        end
        if (n_stale() > 0)
            chk("drain_no_req", 32'(last_req), 32'd0);
        if (alt)
            chk("redirect_no_req", 32'(last_req), 32'd0);
        else if (last_req)
            chk("req_addr", last_addr, model_pc);
        if (!alt && Instr_Valid_IF && !stall) begin
            if (expq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL pop_unexpected: got pc %h, want none",
                         Instr_PC_IF);
            end else begin
                e = expq.pop_front();
                chk("pop_pc", Instr_PC_IF, e.pc);
                chk("pop_instr", Instr1_IF, e.data);
                chk("pop_pc4", Instr_PC_Plus4_IF, e.pc + 32'd4);
            end
            if (npop == 0) begin
                first_pc    = Instr_PC_IF;
                first_instr = Instr1_IF;
                first_p4    = Instr_PC_Plus4_IF;
            end
            if (want_first) begin
                chk("first_after_redirect", Instr_PC_IF, want_pc);
                want_first = 0;
            end
            if (Instr_PC_IF == 32'hFFFFFFFC && Instr_PC_Plus4_IF == 32'h0)
                saw_wrap = 1;
            npop++;
        end
        prev_hold  = Instr_Valid_IF && stall && !alt;
        prev_pc    = Instr_PC_IF;
        prev_instr = Instr1_IF;
        prev_push  = 0;
        if (alt) begin
            model_pc   = {tgt[31:2], 2'b00};
            want_first = 1;
            want_pc    = model_pc;
            foreach (pend[i]) pend[i].stale = 1;
            expq.delete();
        end
        if (rsp) begin
            p = pend.pop_front();
            if (!p.stale) begin
                expq.push_back('{pc: p.addr, data: data_of(p.addr)});
                prev_push = 1;
            end
        end
        if (!alt && last_req && ready) begin
            pend.push_back('{addr: model_pc, age: 0, stale: 1'b0});
            model_pc = model_pc + 32'd4;
        end
        chk("outstanding_bound", 32'(pend.size() <= MAXO), 32'd1);
        foreach (pend[i]) pend[i].age++;
        prev_alt = alt;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic boot_checks();
        RESET = 1'b1;
        cycle();
        chk("boot_idle_req", 32'(last_req), 32'd0);
        cycle();
        chk("first_req", 32'(last_req), 32'd1);
        chk("first_req_addr", last_addr, RPC);
        for (int i = 0; i < 10 && npop == 0; i++) cycle();
        chk("first_pop_seen", 32'(npop > 0), 32'd1);
        chk("first_pop_pc", first_pc, RPC);
        chk("first_pop_pc4", first_p4, RPC + 32'd4);
        chk("first_pop_instr", first_instr, 32'h24080001);
    endtask

    task automatic assert_reset();
        RESET              = 1'b0;
        mif.Mem_Resp_Valid = 1'b0;
        mif.Mem_Resp_Data  = 32'h0;
        #1;
        chk("rst_req", 32'(mif.Mem_Req), 32'd0);
        chk("rst_valid", 32'(Instr_Valid_IF), 32'd0);
        chk("rst_instr", Instr1_IF, 32'h0);
        chk("rst_pc", Instr_PC_IF, 32'h0);
        chk("rst_pc4", Instr_PC_Plus4_IF, 32'h0);
        chk("rst_addr", mif.Mem_Addr, RPC);
        clear_model();
        @(negedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        bit done;
        logic [31:0] held;
        tbl[0]  = '{8,  0, 1, 0, 32'h0,        1, -1};
        tbl[1]  = '{5,  1, 1, 0, 32'h0,        1,  0};
        tbl[2]  = '{6,  0, 1, 0, 32'h0,        1, -1};
        tbl[3]  = '{4,  0, 1, 0, 32'h0,        3, -1};
        tbl[4]  = '{1,  0, 1, 1, 32'h00400003, 3,  0};
        tbl[5]  = '{12, 0, 1, 0, 32'h0,        2, -1};
        tbl[6]  = '{1,  0, 1, 1, 32'hFFFFFFF8, 1,  0};
        tbl[7]  = '{10, 0, 1, 0, 32'h0,        1, -1};
        tbl[8]  = '{3,  1, 0, 0, 32'h0,        1, -1};
        tbl[9]  = '{1,  1, 1, 1, 32'h10000000, 1,  0};
        tbl[10] = '{1,  0, 1, 1, 32'h20000004, 1,  0};
        tbl[11] = '{10, 0, 1, 0, 32'h0,        2, -1};

        stall = 0; ready = 1; alt = 0; tgt = 32'h0; lat = 1;
        saw_wrap = 0;
        STALL = 0; Request_Alt_PC = 0; Alt_PC = 32'h0;
        mif.Mem_Ready = 1'b1;
        RESET = 1'b0;
        mif.Mem_Resp_Valid = 1'b0;
        mif.Mem_Resp_Data  = 32'h0;
        @(negedge CLK);
        assert_reset();
        boot_checks();

        foreach (tbl[k]) begin
            stall = tbl[k].stall;
            ready = tbl[k].ready;
            alt   = tbl[k].alt;
            tgt   = tbl[k].tgt;
            lat   = tbl[k].lat;
            for (int c = 0; c < tbl[k].n; c++) cycle();
            if (tbl[k].exp_req_last >= 0)
                chk($sformatf("vec%0d_req", k), 32'(last_req),
                    32'(tbl[k].exp_req_last));
        end
        alt = 0; stall = 0;
        chk("wrap_seen", 32'(saw_wrap), 32'd1);

        lat = 2; ready = 1; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (pend.size() > 0 && pend[0].age >= lat) begin
                alt = 1; stall = 1; tgt = 32'h30000000;
                cycle();
                done = 1;
            end else begin
                cycle();
            end
        end
        chk("coincident_redirect_hit", 32'(done), 32'd1);
        alt = 0; stall = 1;
        cycle();
        chk("coincident_fifo_empty", 32'(Instr_Valid_IF), 32'd0);
        stall = 0;
        for (int i = 0; i < 8; i++) cycle();

        ready = 0; done = 0;
        for (int i = 0; i < 12 && !done; i++) begin
            cycle();
            done = last_req;
        end
        chk("ready_low_req_seen", 32'(done), 32'd1);
        held = last_addr;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("ready_low_req_held", 32'(last_req), 32'd1);
            chk("ready_low_addr_held", last_addr, held);
        end
        ready = 1;
        lat = 2;
        for (int i = 0; i < 5; i++) cycle();

        assert_reset();
        lat = 1;
        boot_checks();
        for (int i = 0; i < 6; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
